avalon_bus_arbiter: RTL and testbench
=====================================

// Module: avalon_bus_arbiter
// PURPOSE
//  Shares one Avalon-MM memory port between two CPU-side masters: M0 = instruction fetch, M1 = data load/store.
//  Sits between mips_cpu_bus internals and the external memory interface. Uses a registered grant FSM,
//  round-robin fairness, slave waitrequest pass-back and a bus timeout watchdog.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max consecutive slave waitrequest=1 cycles before abort; 0 disables watchdog
// PORTS
//  clk            in   1   system clock; all state updates on rising edge
//  reset          in   1   synchronous, active-low reset
//  m0_address     in   32  fetch byte address
//  m0_read        in   1   fetch read request
//  m0_write       in   1   fetch write request (normally 0; arbitrated like M1)
//  m0_writedata   in   32  fetch write data
//  m0_byteenable  in   4   fetch byte enables
//  m0_waitrequest out  1   stall to M0
//  m0_readdata    out  32  read data to M0
//  m1_*           -    -   same six signals and widths as m0_*, for the data master
//  address        out  32  slave address
//  read           out  1   slave read strobe
//  write          out  1   slave write strobe
//  writedata      out  32  slave write data
//  byteenable     out  4   slave byte enables
//  waitrequest    in   1   slave stall
//  readdata       in   32  slave read data
//  bus_error      out  1   1-cycle pulse on timeout abort or illegal read+write request
// BEHAVIOUR
//  FSM states: IDLE, BUSY0, BUSY1. A master requests when read|write is 1.
//  - IDLE: if exactly one master requests, it is granted. If both request, the master not granted last wins.
//    last_grant resets to 1, so M0 wins the first tie.
//  - On the grant edge: latch that master's address, writedata, byteenable, read and write into slave
//    output registers. Go to BUSYn and update last_grant.
//  - BUSYn: slave command is held stable from the registers. The transfer completes in the first cycle
//    with waitrequest=0. In that cycle mn_waitrequest=0 combinationally. On the next edge: clear
//    read/write, return to IDLE.
//  - Latency: request seen at edge N; slave strobe high from N+1. With a zero-wait slave, the master is
//    released in cycle N+1. Back-to-back transfers have one IDLE bubble cycle.
//  - mn_waitrequest=1 in every cycle except its own completion cycle, including IDLE and while the other
//    master is granted. Masters hold their request stable while stalled.
//  - m0_readdata = m1_readdata = readdata, passed through unregistered; only valid in completion cycle.
//  - Watchdog: a 16-bit counter clears on grant and increments each BUSY cycle with waitrequest=1.
//    When it reaches TIMEOUT_CYCLES:
//    - force completion: mn_waitrequest=0, mn_readdata=32'h0 that cycle;
//    - pulse bus_error; clear the strobes; go to IDLE.
//  - Illegal request (read&write both 1) when granted: treated as a write, read ignored, bus_error pulses
//    on the grant edge.
//  - Reset (reset=0 at an edge) overrides everything, including mid-transfer:
//    - state=IDLE, last_grant=1, counter=0;
//    - address/writedata=0, byteenable=4'b0, read/write=0, bus_error=0;
//    - mn_waitrequest=1 from the next cycle. The aborted transfer is not retried.
//  - Address and byteenable are forwarded unmodified; no alignment or endianness conversion here.
// TESTING
//  1. M0 read 0xBFC00000, slave waitrequest=0: read=1, address=0xBFC00000 one cycle after request;
//     m0_waitrequest=0 same cycle with readdata=0x8C010064.
//  2. M0 and M1 request in the same cycle from reset: M0 served first, then M1 after one bubble. Repeat
//     with both still requesting: M1 is now served before M0.
//  3. M1 write 0xC8, writedata=0x0000007B, byteenable=4'b1111, slave waitrequest high 3 cycles: write held
//     4 cycles with stable data; m1_waitrequest=0 only in cycle 4.
//  4. TIMEOUT_CYCLES=4, slave waitrequest stuck at 1: master released after 4 stall cycles with
//     readdata=0; bus_error pulses once; FSM back in IDLE.
//  5. Reset driven low during BUSY1 with a stalled slave: next cycle read=write=0, both mn_waitrequest=1.
//     After release, a new M0 request is granted first.
//  6. M1 drives read=1 and write=1: slave sees write=1, read=0; bus_error pulses on the grant edge.

Source files
------------

// File: rtl/avalon_bus_arbiter.sv
// Two-master Avalon-MM arbiter: instruction fetch (M0) and data (M1) share one slave port.
// Round-robin tie-break, registered slave command, waitrequest pass-back and a stall watchdog.
module avalon_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,

    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam bit          WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic        last_grant_q;
    logic [15:0] wdog_q;
    logic [31:0] address_q;
    logic [31:0] writedata_q;
    logic [3:0]  byteenable_q;
    logic        read_q;
    logic        write_q;
    logic        bus_error_q;

    logic        req0;
    logic        req1;
    logic        grant0;
    logic        grant1;
    logic        busy;
    logic        timeout_hit;
    logic        done;
    logic [31:0] sel_address;
    logic [31:0] sel_writedata;
    logic [3:0]  sel_byteenable;
    logic        sel_read;
    logic        sel_write;

    always_comb begin
        req0 = m0_read | m0_write;
        req1 = m1_read | m1_write;
        // last_grant_q holds the index of the master served most recently; the other wins a tie.
        grant0 = (state_q == IDLE) && req0 && (!req1 || last_grant_q);
        grant1 = (state_q == IDLE) && req1 && (!req0 || !last_grant_q);
        busy        = (state_q != IDLE);
        timeout_hit = busy && WDOG_EN && (wdog_q == WDOG_LIM);
        done        = busy && (!waitrequest || timeout_hit);

        sel_address    = grant1 ? m1_address    : m0_address;
        sel_writedata  = grant1 ? m1_writedata  : m0_writedata;
        sel_byteenable = grant1 ? m1_byteenable : m0_byteenable;
        sel_read       = grant1 ? m1_read       : m0_read;
        sel_write      = grant1 ? m1_write      : m0_write;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wdog_q       <= 16'd0;
            address_q    <= 32'd0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'b0000;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            bus_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        address_q    <= sel_address;
                        writedata_q  <= sel_writedata;
                        byteenable_q <= sel_byteenable;
                        // A simultaneous read+write is issued as a write and flagged.
                        read_q       <= sel_read & ~sel_write;
                        write_q      <= sel_write;
                        bus_error_q  <= sel_read & sel_write;
                        state_q      <= grant1 ? BUSY1 : BUSY0;
                        last_grant_q <= grant1;
                        wdog_q       <= 16'd0;
                    end
                end
                default: begin
                    if (done) begin
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        bus_error_q <= timeout_hit;
                        state_q     <= IDLE;
                    end else if (waitrequest && (wdog_q != 16'hFFFF)) begin
                        wdog_q <= wdog_q + 16'd1;
                    end
                end
            endcase
        end
    end

    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign read       = read_q;
    assign write      = write_q;
    assign bus_error  = bus_error_q;

    // Release is combinational so a zero-wait slave completes in the first strobe cycle.
    assign m0_waitrequest = !((state_q == BUSY0) && done);
    assign m1_waitrequest = !((state_q == BUSY1) && done);
    assign m0_readdata    = timeout_hit ? 32'h0 : readdata;
    assign m1_readdata    = timeout_hit ? 32'h0 : readdata;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: cycle-level vector table plus randomized M0 write sequences.
module tb_avalon_bus_arbiter;

    localparam logic [31:0] A0 = 32'hBFC0_0000;
    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [3:0]  B0 = 4'b0110;
    localparam logic [31:0] A1 = 32'h0000_00C8;
    localparam logic [31:0] D1 = 32'h0000_007B;
    localparam logic [3:0]  B1 = 4'b1111;
    localparam logic [31:0] RD = 32'h8C01_0064;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m0_writedata, m0_readdata;
    logic        m0_read, m0_write, m0_waitrequest;
    logic [3:0]  m0_byteenable;
    logic [31:0] m1_address, m1_writedata, m1_readdata;
    logic        m1_read, m1_write, m1_waitrequest;
    logic [3:0]  m1_byteenable;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest, bus_error;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .bus_error(bus_error)
    );

    // e_g: 0 = no address check, 1 = M0 command, 2 = M1 command, 3 = reset (all zero)
    typedef struct {
        bit       rst, r0, w0, r1, w1, wt;
        bit       e_rd, e_wr, e_w0, e_w1, e_be;
        bit [1:0] e_g;
        bit       e_to;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    txn_t sb_q[$];
    int   n_cmp = 0;
    int   n_miss = 0;

    function automatic void add(bit rst, bit r0, bit w0, bit r1, bit w1, bit wt,
                                bit e_rd, bit e_wr, bit e_w0, bit e_w1, bit e_be,
                                bit [1:0] e_g, bit e_to);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.wt = wt;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_w0 = e_w0; v.e_w1 = e_w1; v.e_be = e_be;
        v.e_g = e_g; v.e_to = e_to;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t e;
        txn_t t;
        txn_t g;
        int   n;
        int   k;
        bit   fin;

        // reset state
        add(1, 0,0,0,0, 0,  0,0,1,1,0, 3,0);
        // single M0 read, zero-wait slave
        add(1, 1,0,0,0, 0,  0,0,1,1,0, 0,0);
        add(1, 1,0,0,0, 0,  1,0,0,1,0, 1,0);
        add(1, 0,0,0,0, 0,  0,0,1,1,0, 0,0);
        // reset, then ties: M0, M1, M0 with bubbles
        add(0, 0,0,0,0, 0,  0,0,1,1,0, 0,0);
        add(1, 0,0,0,0, 0,  0,0,1,1,0, 3,0);
        add(1, 1,0,1,0, 0,  0,0,1,1,0, 0,0);
        add(1, 1,0,1,0, 0,  1,0,0,1,0, 1,0);
        add(1, 1,0,1,0, 0,  0,0,1,1,0, 0,0);
        add(1, 1,0,1,0, 0,  1,0,1,0,0, 2,0);
        add(1, 1,0,0,0, 0,  0,0,1,1,0, 0,0);
        add(1, 1,0,0,0, 0,  1,0,0,1,0, 1,0);
        add(1, 0,0,0,0, 0,  0,0,1,1,0, 0,0);
        // M1 write, slave stalls 3 cycles
        add(1, 0,0,0,1, 1,  0,0,1,1,0, 0,0);
        add(1, 0,0,0,1, 1,  0,1,1,1,0, 2,0);
        add(1, 0,0,0,1, 1,  0,1,1,1,0, 2,0);
        add(1, 0,0,0,1, 1,  0,1,1,1,0, 2,0);
        add(1, 0,0,0,1, 0,  0,1,1,0,0, 2,0);
        add(1, 0,0,0,0, 0,  0,0,1,1,0, 0,0);
        // M0 read, slave stuck: watchdog abort
        add(1, 1,0,0,0, 1,  0,0,1,1,0, 0,0);
        add(1, 1,0,0,0, 1,  1,0,1,1,0, 1,0);
        add(1, 1,0,0,0, 1,  1,0,1,1,0, 1,0);
        add(1, 1,0,0,0, 1,  1,0,1,1,0, 1,0);
        add(1, 1,0,0,0, 1,  1,0,1,1,0, 1,0);
        add(1, 1,0,0,0, 1,  1,0,0,1,0, 1,1);
        add(1, 0,0,0,0, 0,  0,0,1,1,1, 0,0);
        add(1, 0,0,0,0, 0,  0,0,1,1,0, 0,0);
        // reset during stalled BUSY1, then M0 wins the first tie
        add(1, 0,0,1,0, 1,  0,0,1,1,0, 0,0);
        add(1, 0,0,1,0, 1,  1,0,1,1,0, 2,0);
        add(0, 0,0,1,0, 1,  1,0,1,1,0, 2,0);
        add(1, 1,0,1,0, 0,  0,0,1,1,0, 3,0);
        add(1, 1,0,1,0, 0,  1,0,0,1,0, 1,0);
        add(1, 0,0,1,0, 0,  0,0,1,1,0, 0,0);
        add(1, 0,0,1,0, 0,  1,0,1,0,0, 2,0);
        add(1, 0,0,0,0, 0,  0,0,1,1,0, 0,0);
        // illegal read+write from M1
        add(1, 0,0,1,1, 0,  0,0,1,1,0, 0,0);
        add(1, 0,0,1,1, 0,  0,1,1,0,1, 2,0);
        add(1, 0,0,0,0, 0,  0,0,1,1,0, 0,0);

        reset = 1'b0;
        m0_address = A0; m0_writedata = D0; m0_byteenable = B0; m0_read = 1'b0; m0_write = 1'b0;
        m1_address = A1; m1_writedata = D1; m1_byteenable = B1; m1_read = 1'b0; m1_write = 1'b0;
        waitrequest = 1'b0;
        readdata = RD;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(posedge clk);
            #1;
            reset = v.rst;
            m0_read = v.r0; m0_write = v.w0;
            m1_read = v.r1; m1_write = v.w1;
            waitrequest = v.wt;
            exp_q.push_back(v);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("row%0d read", i), {31'd0, read}, {31'd0, e.e_rd});
            chk($sformatf("row%0d write", i), {31'd0, write}, {31'd0, e.e_wr});
            chk($sformatf("row%0d m0_waitrequest", i), {31'd0, m0_waitrequest}, {31'd0, e.e_w0});
            chk($sformatf("row%0d m1_waitrequest", i), {31'd0, m1_waitrequest}, {31'd0, e.e_w1});
            chk($sformatf("row%0d bus_error", i), {31'd0, bus_error}, {31'd0, e.e_be});
            chk($sformatf("row%0d m0_readdata", i), m0_readdata, e.e_to ? 32'h0 : RD);
            chk($sformatf("row%0d m1_readdata", i), m1_readdata, e.e_to ? 32'h0 : RD);
            if (e.e_g == 2'd1) begin
                chk($sformatf("row%0d address", i), address, A0);
                chk($sformatf("row%0d writedata", i), writedata, D0);
                chk($sformatf("row%0d byteenable", i), {28'd0, byteenable}, {28'd0, B0});
            end else if (e.e_g == 2'd2) begin
                chk($sformatf("row%0d address", i), address, A1);
                chk($sformatf("row%0d writedata", i), writedata, D1);
                chk($sformatf("row%0d byteenable", i), {28'd0, byteenable}, {28'd0, B1});
            end else if (e.e_g == 2'd3) begin
                chk($sformatf("row%0d address", i), address, 32'h0);
                chk($sformatf("row%0d writedata", i), writedata, 32'h0);
                chk($sformatf("row%0d byteenable", i), {28'd0, byteenable}, 32'h0);
            end
        end

        // M0 writes with a random number of slave stall cycles, below the watchdog limit
        for (int j = 0; j < 4; j++) begin
            n = int'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            t.addr = $urandom; t.data = $urandom; t.be = 4'($urandom_range(1, 15));
            m0_address = t.addr; m0_writedata = t.data; m0_byteenable = t.be;
            m0_write = 1'b1;
            waitrequest = 1'b1;
            sb_q.push_back(t);
            k = 0;
            fin = 1'b0;
            while (k < 12 && !fin) begin
                @(negedge clk);
                if (!m0_waitrequest) begin
                    fin = 1'b1;
                end else begin
                    @(posedge clk);
                    #1;
                    k++;
                    waitrequest = (k <= n);
                end
            end
            g = sb_q.pop_front();
            if (!fin) begin
                n_cmp++;
                n_miss++;
                $display("FAIL seq%0d completion: no release within 12 cycles, expected after %0d", j, n + 1);
            end else begin
                chk($sformatf("seq%0d latency", j), k, n + 1);
                chk($sformatf("seq%0d address", j), address, g.addr);
                chk($sformatf("seq%0d writedata", j), writedata, g.data);
                chk($sformatf("seq%0d byteenable", j), {28'd0, byteenable}, {28'd0, g.be});
                chk($sformatf("seq%0d write", j), {31'd0, write}, 32'd1);
                chk($sformatf("seq%0d read", j), {31'd0, read}, 32'd0);
                chk($sformatf("seq%0d bus_error", j), {31'd0, bus_error}, 32'd0);
            end
            @(posedge clk);
            #1;
            m0_write = 1'b0;
            waitrequest = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
